// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: debounce states,
// the column/row-to-hex key map, and the 5-bit "no key" candidate encoding.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } kp_state_e;

  // Candidate MSB set means no key was seen during the scan.
  localparam logic [4:0] KP_NONE = 5'b1_0000;

  // Nibble {col,row} holds the hex legend; row 0 is the top row (Row bit 3).
  localparam logic [63:0] KP_MAP = 64'hDCBA_E963_F852_0741;

  function automatic logic [4:0] kp_code(input logic [1:0] col, input logic [1:0] row);
    logic [5:0] base;
    base = {col, row, 2'b00};
    return {1'b0, KP_MAP[base +: 4]};
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Debounce FSM: turns one candidate per full scan into a clean key event.
// Optional auto-repeat while held is enabled by defining KYPD_REPEAT_EN.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
`ifdef KYPD_REPEAT_EN
  , parameter int REPEAT_SCANS = 250
`endif
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       evt_i,
  input  logic [4:0] cand_i,
  output logic [3:0] code_o,
  output logic       valid_o,
  output logic       held_o
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_SCANS);

  kp_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    key_q, key_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;
  logic          cand_none, cand_is_code, cand_is_key;

`ifdef KYPD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] RPT_DONE = RW'(REPEAT_SCANS);
  logic [RW-1:0] rpt_q, rpt_d, rpt_inc;
  assign rpt_inc = rpt_q + RW'(1);
`endif

  assign cnt_inc      = cnt_q + CNT_ONE;
  assign cand_none    = cand_i[4];
  assign cand_is_code = (cand_i == {1'b0, code_q});
  assign cand_is_key  = (cand_i == {1'b0, key_q});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
`ifdef KYPD_REPEAT_EN
    rpt_d   = rpt_q;
`endif
    if (evt_i) begin
      unique case (state_q)
        IDLE: begin
          if (!cand_none) begin
            key_d = cand_i[3:0];
            if (DEBOUNCE_SCANS == 1) begin
              state_d = HELD;
              cnt_d   = '0;
              code_d  = cand_i[3:0];
              valid_d = 1'b1;
              held_d  = 1'b1;
`ifdef KYPD_REPEAT_EN
              rpt_d   = '0;
`endif
            end else begin
              state_d = PRESS_WAIT;
              cnt_d   = CNT_ONE;
            end
          end
        end
        PRESS_WAIT: begin
          if (cand_none) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cand_is_key) begin
            if (cnt_inc == CNT_DONE) begin
              state_d = HELD;
              cnt_d   = '0;
              code_d  = key_q;
              valid_d = 1'b1;
              held_d  = 1'b1;
`ifdef KYPD_REPEAT_EN
              rpt_d   = '0;
`endif
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            key_d = cand_i[3:0];
            cnt_d = CNT_ONE;
          end
        end
        HELD: begin
          if (cand_is_code) begin
`ifdef KYPD_REPEAT_EN
            if (rpt_inc == RPT_DONE) begin
              valid_d = 1'b1;
              rpt_d   = '0;
            end else begin
              rpt_d = rpt_inc;
            end
`endif
          end else if (DEBOUNCE_SCANS == 1) begin
            state_d = IDLE;
            held_d  = 1'b0;
          end else begin
            state_d = RELEASE_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          // Returning to HELD keeps the original press; no new strobe.
          if (cand_is_code) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_inc == CNT_DONE) begin
            state_d = IDLE;
            cnt_d   = '0;
            held_d  = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
`ifdef KYPD_REPEAT_EN
      rpt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
`ifdef KYPD_REPEAT_EN
      rpt_q   <= rpt_d;
`endif
    end
  end

  assign code_o  = code_q;
  assign valid_o = valid_q;
  assign held_o  = held_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 Pmod keypad scanner: column drive, row sampling, per-scan candidate,
// debounced key event. Define KYPD_REPEAT_EN for auto-repeat while held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS     = 100000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 250
) (
  input  logic       ClkPort,
  input  logic       Reset,
  output logic [3:0] Col,
  input  logic [3:0] Row,
  output logic [3:0] KeyCode,
  output logic       KeyValid,
  output logic       KeyHeld
);

  if (SCAN_TICKS < 2 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_bad_params
    $error("keypad_scanner: parameter below its minimum");
  end

  localparam int TW = $clog2(SCAN_TICKS);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);

  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    col_q, col_d;
  logic [4:0]    acc_q, acc_d;
  logic [4:0]    row_hit, scan_sofar, merged;
  logic          sample, evt;

  always_comb begin
    row_hit = KP_NONE;
    if      (!Row[3]) row_hit = kp_code(col_q, 2'd0);
    else if (!Row[2]) row_hit = kp_code(col_q, 2'd1);
    else if (!Row[1]) row_hit = kp_code(col_q, 2'd2);
    else if (!Row[0]) row_hit = kp_code(col_q, 2'd3);
    // Column 0 starts a fresh scan; later columns only fill an empty result.
    scan_sofar = (col_q == 2'd0) ? KP_NONE : acc_q;
    merged     = scan_sofar[4] ? row_hit : scan_sofar;
    sample     = (tick_q == TICK_LAST);
    evt        = sample && (col_q == 2'd3);
    tick_d     = tick_q + TW'(1);
    col_d      = col_q;
    acc_d      = acc_q;
    if (sample) begin
      tick_d = '0;
      col_d  = col_q + 2'd1;
      acc_d  = merged;
    end
  end

  always_ff @(posedge ClkPort) begin
    if (Reset) begin
      tick_q <= '0;
      col_q  <= 2'd0;
      acc_q  <= KP_NONE;
    end else begin
      tick_q <= tick_d;
      col_q  <= col_d;
      acc_q  <= acc_d;
    end
  end

  assign Col = ~(4'b1000 >> col_q);

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
`ifdef KYPD_REPEAT_EN
    , .REPEAT_SCANS(REPEAT_SCANS)
`endif
  ) u_debounce (
    .clk_i  (ClkPort),
    .rst_i  (Reset),
    .evt_i  (evt),
    .cand_i (merged),
    .code_o (KeyCode),
    .valid_o(KeyValid),
    .held_o (KeyHeld)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad model (SCAN_TICKS=4,
// DEBOUNCE_SCANS=3, REPEAT_SCANS=2 -> 16-cycle scans).
module tb_keypad_scanner;

  localparam int SCAN = 16;

  logic       clk;
  logic       rst;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [15:0] keys;  // bit index = column*4 + row

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;

  keypad_scanner #(
    .SCAN_TICKS(4),
    .DEBOUNCE_SCANS(3),
    .REPEAT_SCANS(2)
  ) dut (
    .ClkPort (clk),
    .Reset   (rst),
    .Col     (col),
    .Row     (row),
    .KeyCode (key_code),
    .KeyValid(key_valid),
    .KeyHeld (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row = 4'b1111;
    for (int c = 0; c < 4; c++)
      if (col[3-c] == 1'b0)
        for (int r = 0; r < 4; r++)
          if (keys[c*4+r]) row[3-r] = 1'b0;
  end

  always @(negedge clk) if (key_valid) pulses++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply a key set for n full scans, then check strobes, code and held flag.
  task automatic step(input string name, input logic [15:0] k, input int n,
                      input int exp_pulses, input logic [3:0] exp_code, input logic exp_held);
    int p0;
    p0 = pulses;
    keys = k;
    repeat (SCAN * n) @(posedge clk);
    @(negedge clk);
    #1;
    check({name, ".pulses"}, pulses - p0, exp_pulses);
    check({name, ".code"}, {28'd0, key_code}, {28'd0, exp_code});
    check({name, ".held"}, {31'd0, key_held}, {31'd0, exp_held});
  endtask

  typedef struct {
    string      name;
    logic [15:0] keys;
    int         scans;
    int         pulses;
    int         pulses_rpt;
    logic [3:0] code;
    logic       held;
  } vec_t;

  localparam logic [15:0] K1 = 16'h0001, K4 = 16'h0002, K7 = 16'h0004, K0 = 16'h0008;
  localparam logic [15:0] K2 = 16'h0010, K5 = 16'h0020, K8 = 16'h0040, KF = 16'h0080;
  localparam logic [15:0] K3 = 16'h0100, K9 = 16'h0400, KA = 16'h1000, KD = 16'h8000;

  vec_t tbl[26];

  initial begin
    int p0;
    logic [1:0] ci;
    tbl[0]  = '{"rel5_a",   16'h0, 2, 0, 0, 4'h5, 1'b1};
    tbl[1]  = '{"rel5_b",   16'h0, 1, 0, 0, 4'h5, 1'b0};
    tbl[2]  = '{"idle",     16'h0, 2, 0, 0, 4'h5, 1'b0};
    tbl[3]  = '{"b9_on2",   K9,    2, 0, 0, 4'h5, 1'b0};
    tbl[4]  = '{"b9_off",   16'h0, 1, 0, 0, 4'h5, 1'b0};
    tbl[5]  = '{"b9_on2b",  K9,    2, 0, 0, 4'h5, 1'b0};
    tbl[6]  = '{"b9_acc",   K9,    1, 1, 1, 4'h9, 1'b1};
    tbl[7]  = '{"b9_hold",  K9,    1, 0, 0, 4'h9, 1'b1};
    tbl[8]  = '{"b9_rel",   16'h0, 3, 0, 0, 4'h9, 1'b0};
    tbl[9]  = '{"k12",      K1|K2, 3, 1, 1, 4'h1, 1'b1};
    tbl[10] = '{"k12_rel",  16'h0, 3, 0, 0, 4'h1, 1'b0};
    tbl[11] = '{"k8",       K8,    4, 1, 1, 4'h8, 1'b1};
    tbl[12] = '{"k8_k3",    K8|K3, 2, 0, 1, 4'h8, 1'b1};
    tbl[13] = '{"k3_only",  K3,    3, 0, 0, 4'h8, 1'b0};
    tbl[14] = '{"k3_acc",   K3,    3, 1, 1, 4'h3, 1'b1};
    tbl[15] = '{"k3_rel",   16'h0, 3, 0, 0, 4'h3, 1'b0};
    tbl[16] = '{"kA",       KA,    3, 1, 1, 4'hA, 1'b1};
    tbl[17] = '{"kA_gap",   16'h0, 1, 0, 0, 4'hA, 1'b1};
    tbl[18] = '{"kA_back",  KA,    1, 0, 0, 4'hA, 1'b1};
    tbl[19] = '{"kA_rel",   16'h0, 3, 0, 0, 4'hA, 1'b0};
    tbl[20] = '{"kD",       KD,    3, 1, 1, 4'hD, 1'b1};
    tbl[21] = '{"kD_rel",   16'h0, 3, 0, 0, 4'hD, 1'b0};
    tbl[22] = '{"k0",       K0,    3, 1, 1, 4'h0, 1'b1};
    tbl[23] = '{"k0_rel",   16'h0, 3, 0, 0, 4'h0, 1'b0};
    tbl[24] = '{"kF",       KF,    3, 1, 1, 4'hF, 1'b1};
    tbl[25] = '{"kF_rel",   16'h0, 3, 0, 0, 4'hF, 1'b0};

    keys = 16'h0;
    rst  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.col", {28'd0, col}, 32'h7);
    check("rst.code", {28'd0, key_code}, 32'h0);
    check("rst.valid", {31'd0, key_valid}, 32'h0);
    check("rst.held", {31'd0, key_held}, 32'h0);
    rst = 1'b0;

    // Column walk: 4 cycles per column, wrapping after column 3.
    for (int k = 0; k < 32; k++) begin
      ci = 2'((k / 4) % 4);
      check("col_walk", {28'd0, col}, {28'd0, ~(4'b1000 >> ci)});
      @(posedge clk);
      #1;
    end

    // Press '5': strobe exactly in the first cycle after the 3rd scan.
    keys = K5;
    repeat (3 * SCAN - 1) @(posedge clk);
    #1;
    check("k5.pre", {31'd0, key_valid}, 32'h0);
    @(posedge clk);
    #1;
    check("k5.strobe", {31'd0, key_valid}, 32'h1);
    check("k5.code", {28'd0, key_code}, 32'h5);
    check("k5.held", {31'd0, key_held}, 32'h1);
    @(posedge clk);
    #1;
    check("k5.post", {31'd0, key_valid}, 32'h0);
    repeat (6 * SCAN - 3 * SCAN - 1) @(posedge clk);
    #1;

    for (int i = 0; i < 26; i++) begin
`ifdef KYPD_REPEAT_EN
      step(tbl[i].name, tbl[i].keys, tbl[i].scans, tbl[i].pulses_rpt, tbl[i].code, tbl[i].held);
`else
      step(tbl[i].name, tbl[i].keys, tbl[i].scans, tbl[i].pulses, tbl[i].code, tbl[i].held);
`endif
    end

    // Reset mid PRESS_WAIT with '7' held: the count must restart from zero.
    p0 = pulses;
    keys = K7;
    repeat (2 * SCAN) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst7.col", {28'd0, col}, 32'h7);
    check("rst7.code", {28'd0, key_code}, 32'h0);
    check("rst7.valid", {31'd0, key_valid}, 32'h0);
    check("rst7.held", {31'd0, key_held}, 32'h0);
    check("rst7.pulses", pulses - p0, 32'h0);
    rst = 1'b0;
    step("k7_2scans", K7, 2, 0, 4'h0, 1'b0);
    step("k7_acc", K7, 1, 1, 4'h7, 1'b1);
    step("k7_rel", 16'h0, 3, 0, 4'h7, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
